// File: rtl/round_robin_arbiter_n.sv
// round_robin_arbiter_n: sticky round-robin arbiter with registered grant; `define RRA_MAX_HOLD_EN adds a MAX_HOLD ownership limit
module round_robin_arbiter_n #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [N-1:0]    incoming_requests,
  output logic [N-1:0]    grant_vector,
  output logic [IDXW-1:0] index,
  output logic            grant_valid
);
  if (N < 2 || N > 32 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("round_robin_arbiter_n: N must be 2..32 and MAX_HOLD >= 1");
  end
  logic [IDXW-1:0] ptr, cand, win;
  logic found, keep, hold_hit, go_idle;
  always_comb begin
    win = ptr;
    cand = ptr;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand = IDXW'((32'(ptr) + 32'(k)) % N);
      if (incoming_requests[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
`ifdef RRA_MAX_HOLD_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  assign hold_hit = (hold_cnt >= HW'(MAX_HOLD)) && |(incoming_requests & ~grant_vector);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hold_cnt <= '0;
    else if (go_idle) hold_cnt <= '0;
    else if (!keep) hold_cnt <= HW'(1);
    else if (hold_cnt < HW'(MAX_HOLD)) hold_cnt <= hold_cnt + HW'(1);
`else
  assign hold_hit = 1'b0;
`endif
  assign keep = grant_valid && incoming_requests[index] && !hold_hit;
  assign go_idle = !enable || (!keep && !found);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      grant_vector <= '0;
      index <= '0;
      grant_valid <= 1'b0;
      ptr <= IDXW'(N - 1);
    end else if (go_idle) begin
      grant_vector <= '0;
      index <= '0;
      grant_valid <= 1'b0;
    end else if (!keep) begin
      grant_vector <= N'(1) << win;
      index <= win;
      grant_valid <= 1'b1;
      ptr <= win;
    end
endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// tb_round_robin_arbiter_n: table-driven scoreboard bench for round_robin_arbiter_n (N=4, MAX_HOLD=3) plus an N=8 instance
module tb_round_robin_arbiter_n;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic en8 = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gv;
  logic [1:0] idx;
  logic gval;
  logic [7:0] req8 = '0;
  logic [7:0] gv8;
  logic [2:0] idx8;
  logic gval8;
  int compared = 0;
  int mismatched = 0;
  typedef struct {logic [3:0] gv; logic [1:0] idx; string name;} exp_t;
  typedef struct {logic [3:0] req; logic en; logic [3:0] gv; logic [1:0] idx;} vec_t;
  exp_t sb[$];
  vec_t vecs[15];
  always #5 clk = ~clk;
  round_robin_arbiter_n #(.N(4), .MAX_HOLD(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .incoming_requests(req),
    .grant_vector(gv), .index(idx), .grant_valid(gval)
  );
  round_robin_arbiter_n #(.N(8), .MAX_HOLD(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .enable(en8), .incoming_requests(req8),
    .grant_vector(gv8), .index(idx8), .grant_valid(gval8)
  );
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    cmp({e.name, "_gv"}, 32'(gv), 32'(e.gv));
    cmp({e.name, "_idx"}, 32'(idx), 32'(e.idx));
    cmp({e.name, "_valid"}, 32'(gval), 32'(|e.gv));
    cmp({e.name, "_onehot"}, 32'($onehot0(gv)), 32'd1);
  endtask
  task automatic apply(input logic [3:0] r, input logic en, input logic [3:0] g, input logic [1:0] i, input string name);
    exp_t e;
    req = r;
    enable = en;
    e.gv = g;
    e.idx = i;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask
  task automatic push_idle(input string name);
    exp_t e;
    e.gv = '0;
    e.idx = '0;
    e.name = name;
    sb.push_back(e);
  endtask
  initial begin
    vecs = '{
      '{4'b0001, 1'b1, 4'b0001, 2'd0}, '{4'b0010, 1'b1, 4'b0010, 2'd1},
      '{4'b0011, 1'b1, 4'b0010, 2'd1}, '{4'b0111, 1'b1, 4'b0010, 2'd1},
      '{4'b0100, 1'b1, 4'b0100, 2'd2}, '{4'b0110, 1'b1, 4'b0100, 2'd2},
      '{4'b0101, 1'b1, 4'b0100, 2'd2}, '{4'b0001, 1'b1, 4'b0001, 2'd0},
      '{4'b1000, 1'b1, 4'b1000, 2'd3}, '{4'b1110, 1'b1, 4'b1000, 2'd3},
      '{4'b0010, 1'b1, 4'b0010, 2'd1}, '{4'b0011, 1'b1, 4'b0010, 2'd1},
      '{4'b0101, 1'b1, 4'b0100, 2'd2}, '{4'b0011, 1'b1, 4'b0001, 2'd0},
      '{4'b0010, 1'b1, 4'b0010, 2'd1}
    };
    #1;
    push_idle("reset_state");
    check_out();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    en8 = 1'b1;
    req8 = 8'h81;
    @(posedge clk);
    #1;
    cmp("n8_wrap_gv", 32'(gv8), 32'h01);
    cmp("n8_wrap_idx", 32'(idx8), 32'd0);
    req8 = 8'h80;
    @(posedge clk);
    #1;
    cmp("n8_last_gv", 32'(gv8), 32'h80);
    cmp("n8_last_idx", 32'(idx8), 32'd7);
    cmp("n8_last_valid", 32'(gval8), 32'd1);
    en8 = 1'b0;
    req8 = '0;
    for (int i = 0; i < 15; i++)
      apply(vecs[i].req, vecs[i].en, vecs[i].gv, vecs[i].idx, $sformatf("sticky%0d", i));
    apply(4'b0010, 1'b0, 4'b0000, 2'd0, "enable_off");
    apply(4'b1111, 1'b1, 4'b0100, 2'd2, "enable_on");
    apply(4'b0000, 1'b1, 4'b0000, 2'd0, "sole_release");
    apply(4'b0100, 1'b1, 4'b0100, 2'd2, "sole_regrant");
    for (int i = 0; i < 5; i++) apply(4'b0000, 1'b1, 4'b0000, 2'd0, $sformatf("idle%0d", i));
    apply(4'b1111, 1'b1, 4'b1000, 2'd3, "after_idle");
    apply(4'b0011, 1'b1, 4'b0001, 2'd0, "wrap");
    #3;
    push_idle("async_reset");
    reset_n = 1'b0;
    #1;
    check_out();
    @(negedge clk);
    reset_n = 1'b1;
    apply(4'b0001, 1'b1, 4'b0001, 2'd0, "post_reset");
`ifdef RRA_MAX_HOLD_EN
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++)
      apply(4'b1111, 1'b1, 4'(1 << ((i / 3) % 4)), 2'((i / 3) % 4), $sformatf("hold%0d", i));
    for (int i = 0; i < 6; i++) apply(4'b0001, 1'b1, 4'b0001, 2'd0, $sformatf("hold_solo%0d", i));
`endif
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
